alu_console: RTL
================

# alu_console

Parametrised operator front-end for the board-level ALU bring-up. It edge-detects the enter and run keys and builds `WIDTH`-bit operands A and B one nibble at a time from switches. It also sequences one ALU operation per run press with a configurable latency, latches the result and the z/o/c/n flags, and pages the result onto `DIGITS` seven-segment nibble slots. It sits between the debounced key/switch inputs and the `alu` and `seg7` instances in the board top level.

## Interface
- `WIDTH`, 32, operand/result width; must be a multiple of `4*DIGITS`.
- `DIGITS`, 4, number of hex digits shown per display page.
- `ALU_LAT`, 1, cycles `control` is held before the result is captured; must be ≥1.

- `clock`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `enter`  in  1  enter key, active-high level (already inverted from KEY).
- `run`  in  1  run key, active-high level.
- `sw_data`  in  4  nibble to load.
- `sw_sel_b`  in  1  0 = load A, 1 = load B.
- `sw_op`  in  3  ALU opcode, sampled on the run edge.
- `sw_show`  in  1  1 = enter pages the display; 0 = enter loads a nibble.
- `alu_result`  in  WIDTH  ALU output.
- `alu_flags`  in  4  {z,o,c,n} from the ALU.
- `bus_a`, `bus_b`  out  WIDTH  operand registers driven to the ALU.
- `control`  out  3  opcode to the ALU; 0 when not issuing.
- `disp_nibbles`  out  4*DIGITS  current result page; nibble 0 is the least significant digit.
- `disp_blank`  out  DIGITS  per-digit blank; all 1 when no valid result.
- `flags_led`  out  4  latched {z,o,c,n}.
- `busy`  out  1  high while an operation is in flight.
- `page`  out  clog2(WIDTH/(4*DIGITS)) (min 1)  current display page index.
- `cnt_a`, `cnt_b`  out  clog2(WIDTH/4)+1  nibbles loaded into each operand.

## Operation
- Edge detect: `enter_q` and `run_q` register the previous level.
  - A rise is `x & ~x_q`.
  - Holding a key produces exactly one event.
- Load (rise of enter, `sw_show`=0, not busy): selected operand ← {operand[WIDTH-5:0], `sw_data`}.
  - The selected count increments and saturates at WIDTH/4. Shifting continues past saturation, so the oldest nibble is discarded.
  - `result_valid` clears.
- Page (rise of enter, `sw_show`=1, not busy): `page` ← `page`+1, wrapping from WIDTH/(4*DIGITS)−1 to 0.
- FSM states are IDLE, ISSUE and CAPTURE.
  - IDLE → ISSUE on a run rise. `op_q` ← `sw_op`, `lat_cnt` ← 0, `busy`=1.
  - ISSUE: `control`=`op_q`; `lat_cnt` increments each cycle. When `lat_cnt`=ALU_LAT−1, go to CAPTURE.
  - CAPTURE: `control`=`op_q`. `result_q` ← `alu_result`, `flags_led` ← `alu_flags`, `result_valid` ← 1, `page` ← 0. Go to IDLE.
  - In IDLE, `control`=0 and `busy`=0.
- While busy, enter and run rises are discarded, not queued.
- Simultaneous enter and run rise in IDLE: run wins and enter is dropped.
- Outputs:
  - `disp_nibbles` = `result_q`[page*4*DIGITS +: 4*DIGITS].
  - `disp_blank` = {DIGITS{~result_valid}}.
- Operands persist across runs until reset or a further load.

## Timing
- Reset values:
  - `bus_a`=`bus_b`=0, `cnt_a`=`cnt_b`=0, `control`=0.
  - `busy`=0, state=IDLE, `result_q`=0, `flags_led`=0.
  - `result_valid`=0, so `disp_blank` is all 1; `page`=0.
  - `enter_q`=`run_q`=0.
- A key held through reset deassertion produces an event on the first clock after reset.
- Load and page take effect at the clock edge that samples the rise. The register is visible the next cycle.
- Run rise sampled at edge T:
  - `busy` and `control` are valid from T through the edge T+ALU_LAT+1.
  - The result is captured at edge T+ALU_LAT+1.
  - `busy` is 0 after that edge.
  - `control` is held ALU_LAT+1 cycles in total.
- The next run rise is accepted at the edge after `busy` falls.
- Reset asserted mid-operation aborts the operation. `control`=0 after that edge and nothing is captured.
- `alu_result` must be stable by the CAPTURE edge; it is not sampled otherwise.

## Test plan
- Nibble load: reset, `sw_sel_b`=0, enter pulses with `sw_data`=1,2,3 → `bus_a`=0x00000123, `cnt_a`=3, `bus_b`=0.
- Overflow: 9 enter pulses into B with data 1..9 → `bus_b`=0x23456789, `cnt_b`=8 (saturated).
- Held key: enter held for 20 cycles → exactly one shift.
- Run latency with ALU_LAT=2 and `sw_op`=3, with the bench ALU returning 0xDEADBEEF and flags 4'b0011:
  - `busy` high 3 cycles, `control`=3 for 3 cycles, then 0.
  - `disp_nibbles`=0xBEEF, `flags_led`=0011, `disp_blank`=0.
- Paging and invalidation: after the run above, enter with `sw_show`=1 → `page`=1 and `disp_nibbles`=0xDEAD. A second enter wraps to `page`=0. A subsequent load sets `disp_blank`=4'hF.
- Priority and abort:
  - Enter and run rise in the same cycle → no operand change, op issued.
  - Run rise while busy → ignored.
  - Reset during ISSUE → `control`=0, `busy`=0, `result_valid`=0 next cycle.

Source files
------------

// File: rtl/alu_console.sv
// alu_console: operator front-end for ALU bring-up.
// Builds operands A/B a nibble at a time from switches, issues one ALU
// operation per run press with a configurable latency, latches the
// result and flags, and pages the result onto a row of hex digits.
module alu_console #(
    parameter int WIDTH   = 32,
    parameter int DIGITS  = 4,
    parameter int ALU_LAT = 1,
    localparam int PG_W   = 4 * DIGITS,
    localparam int NPAGES = WIDTH / PG_W,
    localparam int PW     = (NPAGES > 1) ? $clog2(NPAGES) : 1,
    localparam int CW     = $clog2(WIDTH / 4) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enter,
    input  logic              run,
    input  logic [3:0]        sw_data,
    input  logic              sw_sel_b,
    input  logic [2:0]        sw_op,
    input  logic              sw_show,
    input  logic [WIDTH-1:0]  alu_result,
    input  logic [3:0]        alu_flags,
    output logic [WIDTH-1:0]  bus_a,
    output logic [WIDTH-1:0]  bus_b,
    output logic [2:0]        control,
    output logic [PG_W-1:0]   disp_nibbles,
    output logic [DIGITS-1:0] disp_blank,
    output logic [3:0]        flags_led,
    output logic              busy,
    output logic [PW-1:0]     page,
    output logic [CW-1:0]     cnt_a,
    output logic [CW-1:0]     cnt_b
);

    localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH / 4);
    localparam logic [PW-1:0] PAGE_MAX = PW'(NPAGES - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(ALU_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_enter_q;
    logic              r_run_q;
    logic [2:0]        r_op;
    logic [LW-1:0]     r_lat_cnt;
    logic [WIDTH-1:0]  r_bus_a;
    logic [WIDTH-1:0]  r_bus_b;
    logic [CW-1:0]     r_cnt_a;
    logic [CW-1:0]     r_cnt_b;
    logic [WIDTH-1:0]  r_result;
    logic [3:0]        r_flags;
    logic              r_valid;
    logic [PW-1:0]     r_page;

    logic              w_enter_rise;
    logic              w_run_rise;
    logic              w_idle;
    logic              w_load;
    logic              w_page_step;
    logic              w_busy;
    logic [2:0]        w_control;
    logic [PG_W-1:0]   w_pages [NPAGES];

    // Key events are accepted only in IDLE; run has priority over enter.
    assign w_enter_rise = enter & ~r_enter_q;
    assign w_run_rise   = run & ~r_run_q;
    assign w_idle       = (r_state == S_IDLE);
    assign w_load       = w_idle & w_enter_rise & ~w_run_rise & ~sw_show;
    assign w_page_step  = w_idle & w_enter_rise & ~w_run_rise & sw_show;

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic: IDLE -> ISSUE (ALU_LAT cycles) -> CAPTURE -> IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_run_rise) w_state_next = S_ISSUE;
            S_ISSUE:   if (r_lat_cnt == LAT_LAST) w_state_next = S_CAPTURE;
            S_CAPTURE: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state: opcode is driven for the whole operation
    always_comb begin
        w_busy    = (r_state != S_IDLE);
        w_control = w_busy ? r_op : 3'd0;
    end

    // Key edge history, latched opcode and latency counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_enter_q <= 1'b0;
            r_run_q   <= 1'b0;
            r_op      <= 3'd0;
            r_lat_cnt <= '0;
        end else begin
            r_enter_q <= enter;
            r_run_q   <= run;
            if (w_idle && w_run_rise) begin
                r_op      <= sw_op;
                r_lat_cnt <= '0;
            end else if (r_state == S_ISSUE) begin
                r_lat_cnt <= r_lat_cnt + 1'b1;
            end
        end
    end

    // Operand shift registers; counts saturate but shifting continues
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bus_a <= '0;
            r_bus_b <= '0;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else if (w_load) begin
            if (sw_sel_b) begin
                r_bus_b <= {r_bus_b[WIDTH-5:0], sw_data};
                if (r_cnt_b != CNT_MAX) r_cnt_b <= r_cnt_b + 1'b1;
            end else begin
                r_bus_a <= {r_bus_a[WIDTH-5:0], sw_data};
                if (r_cnt_a != CNT_MAX) r_cnt_a <= r_cnt_a + 1'b1;
            end
        end
    end

    // Result capture, validity and display paging
    always_ff @(posedge clock) begin
        if (reset) begin
            r_result <= '0;
            r_flags  <= 4'd0;
            r_valid  <= 1'b0;
            r_page   <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_result <= alu_result;
            r_flags  <= alu_flags;
            r_valid  <= 1'b1;
            r_page   <= '0;
        end else if (w_load) begin
            r_valid <= 1'b0;
        end else if (w_page_step) begin
            r_page <= (r_page == PAGE_MAX) ? '0 : r_page + 1'b1;
        end
    end

    // Slice the result into display pages
    for (genvar gi = 0; gi < NPAGES; gi++) begin : g_page
        assign w_pages[gi] = r_result[gi*PG_W +: PG_W];
    end

    assign disp_nibbles = w_pages[r_page];
    assign disp_blank   = {DIGITS{~r_valid}};
    assign bus_a        = r_bus_a;
    assign bus_b        = r_bus_b;
    assign cnt_a        = r_cnt_a;
    assign cnt_b        = r_cnt_b;
    assign flags_led    = r_flags;
    assign page         = r_page;
    assign busy         = w_busy;
    assign control      = w_control;

endmodule
